// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM state encoding,
// settle-counter width and a vector-count helper.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Settle counter width; SETTLE is limited to 1..15 so 4 bits suffice.
  localparam int SETTLE_W = 4;

  function automatic int vec_count(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/tt_settle_counter.sv
// Modulo-SETTLE counter: counts while enabled, pulses tc_o on the last count
// and wraps to zero in the same cycle. clr_i restarts it from zero.
module tt_settle_counter
  import truth_table_sweeper_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [SETTLE_W-1:0] LAST = SETTLE_W'(SETTLE - 1);

  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic                tc;

  always_comb begin
    tc = en_i && (cnt_q == LAST);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = tc;

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks stim through every input vector,
// samples dut_y after SETTLE cycles and scores it against a latched table.
// Optional macro TT_CAPTURE_EN adds obs_tt, the captured observed table.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1,
  parameter int CNT_W  = N_IN + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [vec_count(N_IN)-1:0]    exp_tt,
  input  logic                          dut_y,
  output logic [N_IN-1:0]               stim,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [CNT_W-1:0]              err_count,
  output logic [N_IN-1:0]               first_fail,
`ifdef TT_CAPTURE_EN
  output logic [vec_count(N_IN)-1:0]    obs_tt,
`endif
  output logic [1:0]                    dbg_state
);

  localparam int                N_VEC     = vec_count(N_IN);
  localparam logic [CNT_W-1:0]  ERR_MAX   = CNT_W'(N_VEC);
  localparam logic [N_IN-1:0]   STIM_LAST = '1;

  state_e               state_q, state_d;
  logic [N_VEC-1:0]     tt_q, tt_d;
  logic [N_IN-1:0]      stim_q, stim_d;
  logic [CNT_W-1:0]     err_q, err_d;
  logic [N_IN-1:0]      ff_q, ff_d;
  logic                 pass_q, pass_d;
`ifdef TT_CAPTURE_EN
  logic [N_VEC-1:0]     obs_q, obs_d;
`endif

  logic accept;
  logic sweeping;
  logic sample;
  logic mismatch;
  logic last_vec;

  // start is honoured only when no sweep is in flight.
  assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign sweeping = (state_q == S_SWEEP);
  assign mismatch = (dut_y != tt_q[stim_q]);
  assign last_vec = (stim_q == STIM_LAST);

  tt_settle_counter #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (sweeping),
    .tc_o  (sample)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SWEEP;
      S_SWEEP: if (sample && last_vec) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_SWEEP;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: the terminal check precedes the increment, so stim
  // never wraps and rests at the last vector in DONE.
  always_comb begin
    tt_d   = tt_q;
    stim_d = stim_q;
    err_d  = err_q;
    ff_d   = ff_q;
    pass_d = pass_q;
`ifdef TT_CAPTURE_EN
    obs_d  = obs_q;
`endif
    if (accept) begin
      tt_d   = exp_tt;
      stim_d = '0;
      err_d  = '0;
      ff_d   = '0;
      pass_d = 1'b0;
`ifdef TT_CAPTURE_EN
      obs_d  = '0;
`endif
    end else if (sample) begin
      if (mismatch) begin
        if (err_q != ERR_MAX) err_d = err_q + 1'b1;
        if (err_q == '0) ff_d = stim_q;
      end
`ifdef TT_CAPTURE_EN
      obs_d[stim_q] = dut_y;
`endif
      // pass uses err_d so the final vector's result is included.
      if (last_vec) begin
        pass_d = (err_d == '0);
      end else begin
        stim_d = stim_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tt_q   <= '0;
      stim_q <= '0;
      err_q  <= '0;
      ff_q   <= '0;
      pass_q <= 1'b0;
`ifdef TT_CAPTURE_EN
      obs_q  <= '0;
`endif
    end else begin
      tt_q   <= tt_d;
      stim_q <= stim_d;
      err_q  <= err_d;
      ff_q   <= ff_d;
      pass_q <= pass_d;
`ifdef TT_CAPTURE_EN
      obs_q  <= obs_d;
`endif
    end
  end

  // Output logic
  always_comb begin
    busy       = (state_q == S_SWEEP);
    done       = (state_q == S_DONE);
    pass       = pass_q;
    stim       = stim_q;
    err_count  = err_q;
    first_fail = ff_q;
    dbg_state  = state_q;
`ifdef TT_CAPTURE_EN
    obs_tt     = obs_q;
`endif
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: a 3-input/SETTLE=1 instance with a
// selectable reference DUT and a 2-input/SETTLE=3 instance driving XOR.
module tb_truth_table_sweeper;

  localparam int M_MAJ    = 0;
  localparam int M_FAULTY = 1;
  localparam int M_NAND   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 3-input instance
  logic       rst3, start3, dut_y3, busy3, done3, pass3;
  logic [7:0] exp_tt3;
  logic [2:0] stim3, ff3;
  logic [3:0] err3;
  logic [1:0] dbg3;
  int         mode3;
`ifdef TT_CAPTURE_EN
  logic [7:0] obs3;
`endif

  // 2-input instance
  logic       rst2, start2, dut_y2, busy2, done2, pass2;
  logic [3:0] exp_tt2;
  logic [1:0] stim2, ff2;
  logic [2:0] err2;
  logic [1:0] dbg2;
`ifdef TT_CAPTURE_EN
  logic [3:0] obs2;
`endif

  truth_table_sweeper #(.N_IN(3), .SETTLE(1)) u_dut3 (
    .clk(clk), .rst(rst3), .start(start3), .exp_tt(exp_tt3), .dut_y(dut_y3),
    .stim(stim3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_fail(ff3),
`ifdef TT_CAPTURE_EN
    .obs_tt(obs3),
`endif
    .dbg_state(dbg3)
  );

  truth_table_sweeper #(.N_IN(2), .SETTLE(3)) u_dut2 (
    .clk(clk), .rst(rst2), .start(start2), .exp_tt(exp_tt2), .dut_y(dut_y2),
    .stim(stim2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail(ff2),
`ifdef TT_CAPTURE_EN
    .obs_tt(obs2),
`endif
    .dbg_state(dbg2)
  );

  // Reference combinational blocks under test; stim MSB is A.
  always_comb begin
    logic a, b, c, maj;
    a   = stim3[2];
    b   = stim3[1];
    c   = stim3[0];
    maj = (a & b) | (a & c) | (b & c);
    case (mode3)
      M_FAULTY: dut_y3 = maj ^ ((stim3 == 3'd3) || (stim3 == 3'd6));
      M_NAND:   dut_y3 = ~(a & b & c);
      default:  dut_y3 = maj;
    endcase
  end

  assign dut_y2 = stim2[1] ^ stim2[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start on the 3-input instance and count cycles from the first busy
  // cycle to the first done cycle. poke_at >= 0 re-pulses start and flips the
  // table to all-ones at that busy cycle.
  task automatic sweep3(input logic [7:0] tt, input int poke_at, output int cyc);
    exp_tt3 = tt;
    start3  = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    check("busy_first", busy3, 1);
    cyc = 0;
    while (!done3 && cyc < 100) begin
      if (cyc == poke_at) begin
        start3  = 1'b1;
        exp_tt3 = 8'hFF;
      end else begin
        start3 = 1'b0;
      end
      if (busy3) check("stim_step3", stim3, cyc);
      @(negedge clk);
      cyc++;
    end
    start3 = 1'b0;
    if (!done3) check("done3_timeout", 0, 1);
  endtask

  initial begin
    int cyc;
    rst3 = 1'b1; rst2 = 1'b1; start3 = 1'b0; start2 = 1'b0;
    exp_tt3 = 8'h00; exp_tt2 = 4'h0; mode3 = M_MAJ;
    repeat (2) @(negedge clk);

    check("rst_state", dbg3, 0);
    check("rst_stim", stim3, 0);
    check("rst_busy", busy3, 0);
    check("rst_done", done3, 0);
    check("rst_pass", pass3, 0);
    check("rst_err", err3, 0);
    check("rst_ff", ff3, 0);
    rst3 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    check("idle_hold", dbg3, 0);

    // Majority, correct DUT
    mode3 = M_MAJ;
    sweep3(8'b1110_1000, -1, cyc);
    check("maj_len", cyc, 8);
    check("maj_pass", pass3, 1);
    check("maj_err", err3, 0);
    check("maj_ff", ff3, 0);
    check("maj_stim_last", stim3, 7);
    check("maj_busy", busy3, 0);
    check("maj_state", dbg3, 2);

    // Faulty DUT on vectors 3 and 6, restarted from DONE
    mode3 = M_FAULTY;
    sweep3(8'b1110_1000, -1, cyc);
    check("flt_len", cyc, 8);
    check("flt_err", err3, 2);
    check("flt_ff", ff3, 3);
    check("flt_pass", pass3, 0);
    check("flt_done", done3, 1);

    // XOR on the 2-input, SETTLE=3 instance
    exp_tt2 = 4'b0110;
    start2  = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("xor_busy_first", busy2, 1);
    cyc = 0;
    while (!done2 && cyc < 100) begin
      if (busy2) check("xor_hold", stim2, cyc / 3);
      @(negedge clk);
      cyc++;
    end
    if (!done2) check("done2_timeout", 0, 1);
    check("xor_len", cyc, 12);
    check("xor_pass", pass2, 1);
    check("xor_err", err2, 0);
    check("xor_stim_last", stim2, 3);

    // Mid-sweep reset at stim=4 with one error already scored
    mode3   = M_FAULTY;
    exp_tt3 = 8'b1110_1000;
    start3  = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cyc = 0;
    while (stim3 != 3'd4 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_reach4", stim3, 4);
    check("mid_err_pre", err3, 1);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    check("mid_state", dbg3, 0);
    check("mid_stim", stim3, 0);
    check("mid_busy", busy3, 0);
    check("mid_done", done3, 0);
    check("mid_err", err3, 0);
    check("mid_ff", ff3, 0);
    mode3 = M_MAJ;
    sweep3(8'b1110_1000, -1, cyc);
    check("post_rst_len", cyc, 8);
    check("post_rst_pass", pass3, 1);
    check("post_rst_err", err3, 0);

    // start re-pulsed and table flipped mid-sweep: both must be ignored
    sweep3(8'b1110_1000, 3, cyc);
    check("poke_len", cyc, 8);
    check("poke_pass", pass3, 1);
    check("poke_err", err3, 0);

    // Simultaneous rst and start: rst wins
    rst3    = 1'b1;
    start3  = 1'b1;
    @(negedge clk);
    rst3   = 1'b0;
    start3 = 1'b0;
    check("rst_start_state", dbg3, 0);
    check("rst_start_busy", busy3, 0);

`ifdef TT_CAPTURE_EN
    mode3 = M_NAND;
    sweep3(8'b0111_1111, -1, cyc);
    check("nand_obs", obs3, 8'b0111_1111);
    check("nand_pass", pass3, 1);
    exp_tt3 = 8'b0111_1111;
    start3  = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    check("nand_obs_clr", obs3, 0);
    cyc = 0;
    while (!done3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("nand_obs_again", obs3, 8'b0111_1111);
    check("xor_obs", obs2, 4'b0110);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
